// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cpu_pkg                                                      |
// | Description : Shared pipeline-control types and constants.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cpu_pkg;

    typedef logic [1:0] stall_st_t;

    localparam stall_st_t ST_RUN    = 2'd0;
    localparam stall_st_t ST_DCWAIT = 2'd1;
    localparam stall_st_t ST_FLUSH  = 2'd2;

    localparam int FLUSH_CNT_W = 3;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sat_counter                                                  |
// | Description : Up-counter that sticks at all-ones; cleared only by reset.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipeline_stall_ctrl                                          |
// | Description : Stall/flush sequencer for the 5-stage pipeline. Optional     |
// |               performance counters with STALL_PERF_CNT_EN.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipeline_stall_ctrl
    import cpu_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_ld,
    input  logic             use_collision_add,
    input  logic             dc_stall,
    input  logic             flush_req,
    output logic             stall,
    output logic             stall_dly,
    output logic             stall_ex,
    output logic             stall_ma,
    output logic             stall_wb,
    output logic             stall_fin2,
    output logic             rst_pipe
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] ld_stall_cnt,
    output logic [CNT_W-1:0] dc_stall_cnt
`endif
);

    localparam logic [FLUSH_CNT_W-1:0] c_fl_load = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [FLUSH_CNT_W-1:0] c_fl_one  = FLUSH_CNT_W'(1);

    stall_st_t              r_state;
    stall_st_t              w_state_nxt;
    logic [FLUSH_CNT_W-1:0] r_fl_cnt;
    logic [FLUSH_CNT_W-1:0] w_fl_cnt_nxt;
    logic                   r_flush_pend;
    logic                   w_flush_pend_nxt;
    logic                   w_flushing;
    logic                   w_id_req;
    logic                   w_bub_id;
    logic                   r_stall_dly;
    logic                   r_stall_ex;
    logic                   r_stall_ma;
    logic                   r_stall_wb;
    logic                   r_stall_fin2;

    assign w_flushing = (r_state == ST_FLUSH);
    assign w_id_req   = stall_ld | use_collision_add;
    assign w_bub_id   = w_id_req & ~dc_stall;

    // ID-side requests are masked while flushing: the slots are being killed anyway.
    assign stall    = dc_stall | (w_id_req & ~w_flushing);
    assign rst_pipe = w_flushing;

    always_comb begin
        w_state_nxt      = r_state;
        w_fl_cnt_nxt     = r_fl_cnt;
        w_flush_pend_nxt = r_flush_pend;
        case (r_state)
            ST_RUN: begin
                if (dc_stall) begin
                    w_state_nxt      = ST_DCWAIT;
                    w_flush_pend_nxt = r_flush_pend | flush_req;
                end else if (flush_req || r_flush_pend) begin
                    w_state_nxt      = ST_FLUSH;
                    w_fl_cnt_nxt     = c_fl_load;
                    w_flush_pend_nxt = 1'b0;
                end
            end
            ST_DCWAIT: begin
                if (dc_stall) begin
                    w_flush_pend_nxt = r_flush_pend | flush_req;
                end else if (flush_req || r_flush_pend) begin
                    w_state_nxt      = ST_FLUSH;
                    w_fl_cnt_nxt     = c_fl_load;
                    w_flush_pend_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (r_fl_cnt == '0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_fl_cnt_nxt = r_fl_cnt - c_fl_one;
                end
            end
            default: begin
                w_state_nxt      = ST_RUN;
                w_fl_cnt_nxt     = '0;
                w_flush_pend_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_fl_cnt     <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fl_cnt     <= w_fl_cnt_nxt;
            r_flush_pend <= w_flush_pend_nxt;
        end
    end

    // A flush takes priority over a miss freeze when both would shape the bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_dly  <= 1'b0;
            r_stall_ex   <= 1'b0;
            r_stall_ma   <= 1'b0;
            r_stall_wb   <= 1'b0;
            r_stall_fin2 <= 1'b0;
        end else begin
            r_stall_dly  <= stall;
            r_stall_fin2 <= r_stall_wb;
            if (w_flushing) begin
                r_stall_ex <= 1'b1;
                r_stall_ma <= 1'b1;
                r_stall_wb <= r_stall_ma;
            end else if (dc_stall) begin
                r_stall_wb <= 1'b1;
            end else begin
                r_stall_ex <= w_bub_id;
                r_stall_ma <= r_stall_ex;
                r_stall_wb <= r_stall_ma;
            end
        end
    end

    assign stall_dly  = r_stall_dly;
    assign stall_ex   = r_stall_ex;
    assign stall_ma   = r_stall_ma;
    assign stall_wb   = r_stall_wb;
    assign stall_fin2 = r_stall_fin2;

`ifdef STALL_PERF_CNT_EN
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_ld_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_bub_id),
        .count (ld_stall_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_dc_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (dc_stall),
        .count (dc_stall_cnt)
    );
`else
    // CNT_W only sizes the counters; keep it referenced when they are compiled out.
    if (CNT_W < 1) begin : g_no_perf_cnt
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipeline_stall_ctrl                                       |
// | Description : Self-checking bench: vector table, corner sequences and a    |
// |               randomized run against a behavioural model.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pipeline_stall_ctrl;

    localparam int FC      = 2;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall_ld = 1'b0;
    logic use_collision_add = 1'b0;
    logic dc_stall = 1'b0;
    logic flush_req = 1'b0;
    logic stall, stall_dly, stall_ex, stall_ma, stall_wb, stall_fin2, rst_pipe;
`ifdef STALL_PERF_CNT_EN
    logic [CW-1:0] ld_stall_cnt, dc_stall_cnt;
`endif

    pipeline_stall_ctrl #(
        .FLUSH_CYCLES (FC),
        .CNT_W        (CW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall_ld          (stall_ld),
        .use_collision_add (use_collision_add),
        .dc_stall          (dc_stall),
        .flush_req         (flush_req),
        .stall             (stall),
        .stall_dly         (stall_dly),
        .stall_ex          (stall_ex),
        .stall_ma          (stall_ma),
        .stall_wb          (stall_wb),
        .stall_fin2        (stall_fin2),
        .rst_pipe          (rst_pipe)
`ifdef STALL_PERF_CNT_EN
        ,
        .ld_stall_cnt      (ld_stall_cnt),
        .dc_stall_cnt      (dc_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: remaining flush cycles, miss-wait flag, pending flush, bubble pipe.
    int m_fl_left;
    bit m_wait, m_pend, m_stall_prev;
    bit m_bub [4];
    int m_ldc, m_dcc;
    logic seen_rst, seen_stall;

    typedef struct {
        bit       ld, uca, dc, fr;
        bit [6:0] exp;   // {stall, stall_dly, rst_pipe, ex, ma, wb, fin2}
    } vec_t;
    vec_t tbl [13];

    function automatic logic [6:0] outs();
        return {stall, stall_dly, rst_pipe, stall_ex, stall_ma, stall_wb, stall_fin2};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fl_left = 0; m_wait = 0; m_pend = 0; m_stall_prev = 0;
        for (int i = 0; i < 4; i++) m_bub[i] = 0;
        m_ldc = 0; m_dcc = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        stall_ld = 0; use_collision_add = 0; dc_stall = 0; flush_req = 0;
        rst_n = 0;
        #1;
        chk("reset_outputs", 32'(outs()), 32'd0);
        model_reset();
        #2 rst_n = 1;
    endtask

    task automatic cycle(input bit ld, input bit uca, input bit dc, input bit fr);
        bit flushing, e_stall, bub;
        @(negedge clk);
        stall_ld = ld; use_collision_add = uca; dc_stall = dc; flush_req = fr;
        #1;
        flushing = (m_fl_left > 0);
        e_stall  = dc | ((ld | uca) & !flushing);
        chk("stall", 32'(stall), 32'(e_stall));
        chk("stall_dly", 32'(stall_dly), 32'(m_stall_prev));
        chk("rst_pipe", 32'(rst_pipe), 32'(flushing));
        chk("bubbles", {28'd0, stall_ex, stall_ma, stall_wb, stall_fin2},
            {28'd0, m_bub[0], m_bub[1], m_bub[2], m_bub[3]});
`ifdef STALL_PERF_CNT_EN
        chk("ld_stall_cnt", 32'(ld_stall_cnt), 32'(m_ldc));
        chk("dc_stall_cnt", 32'(dc_stall_cnt), 32'(m_dcc));
`endif
        seen_rst   = rst_pipe;
        seen_stall = stall;
        @(posedge clk);
        bub = (ld | uca) & !dc;
        m_stall_prev = e_stall;
        m_bub[3] = m_bub[2];
        if (flushing) begin
            m_bub[2] = m_bub[1]; m_bub[0] = 1; m_bub[1] = 1;
        end else if (dc) begin
            m_bub[2] = 1;
        end else begin
            m_bub[2] = m_bub[1]; m_bub[1] = m_bub[0]; m_bub[0] = bub;
        end
        if (bub && m_ldc < CNT_MAX) m_ldc++;
        if (dc && m_dcc < CNT_MAX) m_dcc++;
        if (flushing) begin
            m_fl_left--;
        end else if (dc) begin
            m_wait = 1;
            m_pend = m_pend | fr;
        end else begin
            m_wait = 0;
            if (fr || m_pend) begin
                m_fl_left = FC;
                m_pend = 0;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit dc_lvl;
        bit exp_rst [4];

        tbl[0]  = '{1, 0, 0, 0, 7'b1000000};
        tbl[1]  = '{0, 0, 0, 0, 7'b0101000};
        tbl[2]  = '{0, 0, 0, 0, 7'b0000100};
        tbl[3]  = '{0, 0, 0, 0, 7'b0000010};
        tbl[4]  = '{0, 0, 0, 0, 7'b0000001};
        tbl[5]  = '{0, 0, 0, 1, 7'b0000000};
        tbl[6]  = '{0, 0, 0, 0, 7'b0010000};
        tbl[7]  = '{0, 0, 0, 0, 7'b0011100};
        tbl[8]  = '{0, 0, 0, 0, 7'b0001110};
        tbl[9]  = '{0, 0, 0, 0, 7'b0000111};
        tbl[10] = '{0, 0, 0, 0, 7'b0000011};
        tbl[11] = '{0, 0, 0, 0, 7'b0000001};
        tbl[12] = '{0, 0, 0, 0, 7'b0000000};

        #1;
        chk("reset_state", 32'(outs()), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            stall_ld = tbl[i].ld; use_collision_add = tbl[i].uca;
            dc_stall = tbl[i].dc; flush_req = tbl[i].fr;
            #1;
            chk($sformatf("table_row%0d", i), 32'(outs()), 32'(tbl[i].exp));
            @(posedge clk);
        end
`ifdef STALL_PERF_CNT_EN
        chk("ld_cnt_after_loaduse", 32'(ld_stall_cnt), 32'd1);
`endif

        // Flush and load-use together: flush wins, next load-use is masked.
        do_reset();
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 0);
        chk("ld_masked_in_flush", 32'(seen_stall), 32'd0);
        chk("flush_over_ld", 32'(seen_rst), 32'd1);
        repeat (4) cycle(0, 0, 0, 0);

        // D-cache miss held five cycles.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 1, 0);
            chk("dc_stall_freeze", 32'(seen_stall), 32'd1);
        end
        cycle(0, 0, 0, 0);
        chk("dc_release", 32'(seen_stall), 32'd0);
`ifdef STALL_PERF_CNT_EN
        chk("dc_cnt_5", 32'(dc_stall_cnt), 32'd5);
`endif
        repeat (3) cycle(0, 0, 0, 0);

        // Flush request during a three-cycle miss is deferred.
        do_reset();
        cycle(0, 0, 1, 0);
        chk("no_flush_in_miss0", 32'(seen_rst), 32'd0);
        cycle(0, 0, 1, 1);
        chk("no_flush_in_miss1", 32'(seen_rst), 32'd0);
        cycle(0, 0, 1, 0);
        chk("no_flush_in_miss2", 32'(seen_rst), 32'd0);
        exp_rst = '{0, 1, 1, 0};
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0);
            chk($sformatf("pend_flush_c%0d", i), 32'(seen_rst), 32'(exp_rst[i]));
        end

        // Reset on the first rst_pipe cycle.
        do_reset();
        cycle(0, 0, 0, 1);
        @(negedge clk);
        flush_req = 0;
        #1;
        chk("mid_flush_active", 32'(rst_pipe), 32'd1);
        rst_n = 0;
        #1;
        chk("mid_flush_reset", 32'(outs()), 32'd0);
        model_reset();
        #1 rst_n = 1;
        repeat (3) cycle(0, 0, 0, 0);

`ifdef STALL_PERF_CNT_EN
        do_reset();
        repeat (20) cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        chk("dc_cnt_saturate", 32'(dc_stall_cnt), 32'd15);
`endif

        do_reset();
        dc_lvl = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            if ($urandom_range(0, 7) == 0) dc_lvl = !dc_lvl;
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, dc_lvl,
                  $urandom_range(0, 9) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall and flush sequencer for the 5-stage RV32I pipeline. Merges the load-use stall from the forwarding unit, the collision stall, D-cache miss stalls and EX-stage flush requests. Produces the freeze signal, the per-stage bubble markers (`stall_ex`/`_ma`/`_wb`/`_fin2`) and the `rst_pipe` flush pulse that the forwarding unit and stage registers consume. Sits beside the forwarding unit and is driven from the EX and MA stages.

## Interface
- `FLUSH_CYCLES`, default 2: width of the `rst_pipe` pulse in cycles; legal range 1–7.
- `CNT_W`, default 32: width of the performance counters.

Ports (clock and reset first):
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall_ld` in 1: load-use hazard request from the forwarding unit.
- `use_collision_add` in 1: extra one-cycle ID stall request.
- `dc_stall` in 1: D-cache miss, level signal, held until data returns.
- `flush_req` in 1: EX taken branch/jump/trap, single-cycle pulse.
- `stall` out 1: freeze IF/ID/PC, combinational.
- `stall_dly` out 1: `stall` delayed by one cycle.
- `stall_ex`, `stall_ma`, `stall_wb`, `stall_fin2` out 1 each: slot in that stage is a bubble.
- `rst_pipe` out 1: flush pulse.
- `ld_stall_cnt` out `CNT_W`: only with the counter macro.
- `dc_stall_cnt` out `CNT_W`: only with the counter macro.

## Operation
- FSM states:
  - RUN (reset state).
  - DCWAIT.
  - FLUSH, with a 3-bit down-counter `fl_cnt`.
- RUN:
  - `dc_stall` → DCWAIT.
  - Otherwise, `flush_req` or pending flush → FLUSH with `fl_cnt`=FLUSH_CYCLES-1.
- DCWAIT:
  - Stays while `dc_stall`=1.
  - On `dc_stall` falling: → FLUSH if a flush is pending, else → RUN.
- FLUSH:
  - `rst_pipe`=1.
  - `fl_cnt` decrements each cycle; at 0 → RUN.
  - A `dc_stall` arriving in FLUSH is ignored until return to RUN.
- `stall` = `dc_stall` | ((`stall_ld` | `use_collision_add`) & state≠FLUSH).
- Bubble id: `bub_id` = (`stall_ld` | `use_collision_add`) & ~`dc_stall`.
- Bubble shift (registered), by condition:
  - Normal: `stall_ex`←`bub_id`, `stall_ma`←`stall_ex`, `stall_wb`←`stall_ma`, `stall_fin2`←`stall_wb`.
  - `dc_stall`=1: `stall_ex` and `stall_ma` hold; `stall_wb`←1; `stall_fin2`←`stall_wb`.
  - `rst_pipe`=1: `stall_ex`←1, `stall_ma`←1; the rest shift normally.
- Pending flush: `flush_req` while `dc_stall`=1 sets `flush_pend`. It is cleared on entry to FLUSH.
- A second `flush_req` during FLUSH is dropped (the EX slot is already killed).

## Timing
- All outputs are 0 at reset except `stall`, which follows its inputs combinationally (0 when inputs are 0).
- `stall`: zero latency.
- `stall_dly` and all bubble markers: one-cycle latency.
- `rst_pipe` latency:
  - Asserted the cycle after `flush_req` is accepted in RUN.
  - Held exactly FLUSH_CYCLES cycles.
  - With a pending flush, asserts the cycle after `dc_stall` drops.
- Simultaneous `flush_req` and `stall_ld` in RUN: flush wins. `stall_ld` is masked during FLUSH.
- Simultaneous `dc_stall` and `flush_req`: DCWAIT plus pending flush.
- `rst_n` asserted mid-operation: immediate return to RUN. Clears pending flush, counters and every register.

## Configuration
- `STALL_PERF_CNT_EN` defined:
  - `ld_stall_cnt` increments each cycle `bub_id`=1.
  - `dc_stall_cnt` increments each cycle `dc_stall`=1.
  - Both saturate at all-ones and clear on reset only.
- Undefined: counter ports absent, no counter logic.

## Structure
- Shared package `cpu_pkg` holds:
  - state encoding typedef `stall_st_t` (RUN=2'd0, DCWAIT=2'd1, FLUSH=2'd2);
  - constant `FLUSH_CNT_W`=3.
- One sub-module: `sat_counter` (param width, `inc` input, saturating). Instantiated twice under the macro.

## Test plan
- **Load-use.** `stall_ld`=1 for 1 cycle in RUN → `stall`=1 that cycle; `stall_ex`=1, `stall_ma`=1, `stall_wb`=1, `stall_fin2`=1 on cycles +1 through +4; `ld_stall_cnt`=1.
- **D-cache stall.** `dc_stall` held 5 cycles → `stall`=1 for 5 cycles; `stall_wb`=1 during them; `stall_ex` and `stall_ma` unchanged; `dc_stall_cnt`=5; FSM returns to RUN.
- **Flush.** `flush_req` pulse in RUN with FLUSH_CYCLES=2 → `rst_pipe`=1 on cycles +1 and +2; `stall_ex`=1 on +2 and +3.
- **Flush during miss.** `flush_req` during a 3-cycle `dc_stall` → no `rst_pipe` during the stall; `rst_pipe` for 2 cycles starting the cycle after `dc_stall` falls.
- **Mid-flush reset.** `rst_n` pulsed low on the first `rst_pipe` cycle → `rst_pipe`=0 and all bubble markers 0 immediately; FSM in RUN.
- **Counter saturation.** CNT_W=4, `dc_stall` held 20 cycles → `dc_stall_cnt`=15.
